// File: rtl/bus_interconnect.sv
// bus_interconnect: N-master x M-slave shared bus with registered round-robin
// arbitration, table-driven address decode and per-transaction slave timeout.
module bus_interconnect #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEC_BITS = 4,
    parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLAVE_REGION = {4'h3, 4'h2, 4'h1, 4'hF},
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_breq,
    output logic [NUM_MASTERS-1:0]        m_bgnt,
    input  logic [NUM_MASTERS-1:0]        m_bstart,
    input  logic [NUM_MASTERS-1:0]        m_bwrite,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*2-1:0]      m_tsize,
    output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]        m_bdone,
    output logic [NUM_MASTERS-1:0]        m_berror,
    output logic [NUM_SLAVES-1:0]         s_ss,
    output logic                          s_bstart,
    output logic                          s_bwrite,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [1:0]                    s_tsize,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
    input  logic [NUM_SLAVES-1:0]         s_bdone
);
    localparam int OW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, OWNED, XFER, ERR} state_t;

    state_t state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, pick, cand, next_rr;
    logic [SW-1:0] idx_q, idx_d, dec_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] bgnt_q, bgnt_d;
    logic any_req, dec_hit, start, done, expire, keep;

    assign s_addr   = m_addr[owner_q*ADDR_W +: ADDR_W];
    assign s_wdata  = m_wdata[owner_q*DATA_W +: DATA_W];
    assign s_tsize  = m_tsize[owner_q*2 +: 2];
    assign s_bwrite = m_bwrite[owner_q];
    assign start    = state_q == OWNED && m_bstart[owner_q];
    assign s_bstart = start;
    assign done     = state_q == XFER && s_bdone[idx_q];
    assign expire   = TIMEOUT != 0 && int'(cnt_q) + 2 >= TIMEOUT;
    assign keep     = m_breq[owner_q];
    assign next_rr  = OW'((int'(owner_q) + 1) % NUM_MASTERS);
    assign m_bgnt   = bgnt_q;

    // Descending scan so the smallest offset from the rr pointer wins.
    always_comb begin
        pick = rr_q;
        cand = rr_q;
        any_req = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            cand = OW'((int'(rr_q) + i) % NUM_MASTERS);
            if (m_breq[cand]) begin
                pick = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (s_addr[ADDR_W-1 -: DEC_BITS] == SLAVE_REGION[i*DEC_BITS +: DEC_BITS]) begin
                dec_hit = 1'b1;
                dec_idx = SW'(i);
            end
        end
    end

    // A released request ends ownership as soon as the transaction completes.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d = rr_q;
        idx_d = idx_q;
        cnt_d = state_q == XFER ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OWNED;
                    owner_d = pick;
                end
            end
            OWNED: begin
                if (start) begin
                    state_d = dec_hit ? XFER : ERR;
                    idx_d = dec_idx;
                    cnt_d = '0;
                end else if (!keep) begin
                    state_d = IDLE;
                    rr_d = next_rr;
                end
            end
            XFER: begin
                if (done) begin
                    state_d = keep ? OWNED : IDLE;
                    rr_d = keep ? rr_q : next_rr;
                end else if (expire) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                state_d = keep ? OWNED : IDLE;
                rr_d = keep ? rr_q : next_rr;
            end
            default: state_d = IDLE;
        endcase
        bgnt_d = state_d == IDLE ? '0 : NUM_MASTERS'(1'b1) << owner_d;
    end

    always_comb begin
        s_ss = '0;
        m_bdone = '0;
        m_berror = '0;
        m_rdata = '0;
        if (start && dec_hit) s_ss[dec_idx] = 1'b1;
        if (state_q == XFER) begin
            s_ss[idx_q] = 1'b1;
            m_bdone[owner_q] = s_bdone[idx_q];
            m_rdata[owner_q*DATA_W +: DATA_W] = s_rdata[idx_q*DATA_W +: DATA_W];
        end
        if (state_q == ERR) begin
            m_bdone[owner_q] = 1'b1;
            m_berror[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            bgnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            bgnt_q <= bgnt_d;
        end
    end
endmodule
